sp_ram_bist: RTL
================

// Module: sp_ram_bist
// PURPOSE
//  Parametrised single-port synchronous RAM with valid/ready request port, byte-write enables,
//  configurable read latency and a built-in march self-test (W0,R0,W1,R1). It is the successor
//  of the fixed 8x8 single-port RAM. It sits between a local bus master and on-chip storage, and
//  reports pass/fail plus the first failing address after power-up or on demand.
// PARAMETERS
//  DATA_WIDTH     8                   word width; must be a multiple of 8
//  RAM_DEPTH      8                   number of words; any value >= 2 (non-power-of-2 allowed)
//  ADDR_WIDTH     $clog2(RAM_DEPTH)   address width (derived)
//  READ_LATENCY   1                   cycles from read accept to rd_valid_op; legal values 1 or 2
//  FAULT_ADDR     -1                  sim-only stuck-at-0 on bit 0 of this word; -1 = disabled
// PORTS
//  clk_ip             in   1             clock; all logic on rising edge
//  rst_n_ip           in   1             reset; one clock; reset is asynchronous and active-low
//  req_valid_ip       in   1             user request valid
//  req_ready_op       out  1             block accepts request; = (state==IDLE) && !bist_start_ip
//  we_ip              in   1             1 = write, 0 = read (qualified by accept)
//  be_ip              in   DATA_WIDTH/8  byte write enables; be_ip[i] covers data bits [8i+7:8i]
//  address_ip         in   ADDR_WIDTH    word address
//  data_ip            in   DATA_WIDTH    write data
//  rd_valid_op        out  1             one-cycle pulse: rd_data_op valid
//  rd_data_op         out  DATA_WIDTH    read data; holds last returned value
//  bist_start_ip      in   1             start self-test (sampled in IDLE only)
//  bist_busy_op       out  1             self-test running
//  bist_done_op       out  1             one-cycle pulse at end of self-test
//  bist_pass_op       out  1             1 = last self-test found no mismatch
//  bist_fail_addr_op  out  ADDR_WIDTH    first mismatching address of last self-test
// BEHAVIOUR
//  Reset: req_ready_op=1 (IDLE), rd_valid_op=0, rd_data_op=0, bist_busy_op=0, bist_done_op=0,
//   bist_pass_op=0, bist_fail_addr_op=0. Array is NOT reset; contents undefined until written.
//  Accept = req_valid_ip && req_ready_op on a rising edge; one request per cycle max.
//  Write: bytes with be_ip set are updated at the accept edge; be_ip==0 is a legal no-op.
//  Read: array sampled at the accept edge; rd_valid_op pulses exactly READ_LATENCY cycles later.
//   Back-to-back reads every cycle give back-to-back rd_valid_op pulses, in order.
//  Write then read of the same address on the next cycle returns the new data (no stale read).
//  address_ip >= RAM_DEPTH: write dropped; read returns 0 with normal rd_valid_op timing.
//  BIST FSM: IDLE -> W0 -> R0 -> W1 -> R1 -> DRAIN -> IDLE.
//   bist_start_ip in IDLE wins over a same-cycle req_valid_ip (req_ready_op=0 that cycle).
//   W0/W1 write all-0/all-1 to addresses 0..RAM_DEPTH-1 ascending, one word per cycle.
//   R0/R1 read 0..RAM_DEPTH-1 ascending and compare with 0/all-1 on return.
//   DRAIN waits READ_LATENCY cycles for the last compare, then pulses bist_done_op for 1 cycle.
//   bist_busy_op is high for exactly 4*RAM_DEPTH+READ_LATENCY cycles; bist_pass_op and
//    bist_fail_addr_op update at done and hold until the next start.
//   A mismatch never aborts the test; only the first failing address is captured.
//   BIST reads never assert rd_valid_op. User reads accepted before the start still return.
//   bist_start_ip while busy is ignored. Array holds all-1 after a completed self-test.
//  Reset mid-operation: FSM to IDLE, in-flight reads dropped (no rd_valid_op), no done pulse.
// STRUCTURE
//  Package sp_ram_pkg: bist_state_t enum {IDLE,W0,R0,W1,R1,DRAIN}, constants for the all-0 and
//   all-1 patterns, and a byte-merge function (old word, new word, be -> merged word).
//  Sub-module sp_ram_array: storage, byte-enable write, READ_LATENCY read pipeline, and the
//   FAULT_ADDR model. The top level holds the BIST FSM, the request mux and the result registers.
// TESTING
//  Reset then write 0xA5 @3 with be=1, read @3 -> rd_valid_op after READ_LATENCY, rd_data_op=0xA5.
//  DATA_WIDTH=16: write 0x1234 @2, then write 0xFF00 @2 with be=2'b10, read @2 -> 0xFF34.
//  Back-to-back reads @0..7 after writing word k=k -> 8 consecutive rd_valid_op, data 0..7 in order.
//  bist_start_ip and req_valid_ip in the same cycle -> request not accepted; busy for 32+READ_LATENCY
//   cycles (depth 8); done pulses once with pass=1; reading any address afterwards returns 0xFF.
//  FAULT_ADDR=5 -> bist_pass_op=0, bist_fail_addr_op=5. Rerun with FAULT_ADDR=-1 -> pass=1.
//  Assert rst_n_ip during R0 -> busy=0, no done pulse, no rd_valid_op; a new start completes normally.

Source files
------------

// File: rtl/sp_ram_pkg.sv
// Shared types and helpers for the single-port RAM with built-in march self-test.
package sp_ram_pkg;

  typedef enum logic [2:0] {StIdle, StW0, StR0, StW1, StR1, StDrain} bist_state_t;

  // Widest word the helpers support; callers size down with a slice.
  localparam int unsigned MaxDataWidth = 256;
  localparam int unsigned MaxBytes     = MaxDataWidth / 8;

  typedef logic [MaxDataWidth-1:0] word_t;
  typedef logic [MaxBytes-1:0]     be_t;

  localparam word_t PatZero = '0;
  localparam word_t PatOnes = '1;

  function automatic word_t byte_merge(input word_t old_word, input word_t new_word,
                                       input be_t be);
    word_t merged;
    merged = old_word;
    for (int unsigned i = 0; i < MaxBytes; i++) begin
      if (be[i]) merged[8*i +: 8] = new_word[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/sp_ram_array.sv
// Word storage with byte-enable writes, a 1- or 2-stage read pipeline carrying a request tag,
// and an optional stuck-at-0 fault on bit 0 of one word.
module sp_ram_array
  import sp_ram_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned RAM_DEPTH    = 8,
  parameter int unsigned ADDR_WIDTH   = $clog2(RAM_DEPTH),
  parameter int unsigned READ_LATENCY = 1,
  parameter int          FAULT_ADDR   = -1,
  parameter int unsigned TAG_WIDTH    = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req,
  input  logic                    we,
  input  logic [DATA_WIDTH/8-1:0] be,
  input  logic [ADDR_WIDTH-1:0]   addr,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [TAG_WIDTH-1:0]    tag,
  output logic                    rd_valid,
  output logic [TAG_WIDTH-1:0]    rd_tag,
  output logic [DATA_WIDTH-1:0]   rd_data
);

  localparam logic [ADDR_WIDTH:0]   DepthExt = RAM_DEPTH[ADDR_WIDTH:0];
  localparam bit                    FaultEn  = (FAULT_ADDR >= 0) && (FAULT_ADDR < int'(RAM_DEPTH));
  localparam logic [ADDR_WIDTH-1:0] FaultIdx = FaultEn ? FAULT_ADDR[ADDR_WIDTH-1:0] : '0;

  logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];
  logic                  in_range;
  logic [DATA_WIDTH-1:0] cur_word;
  logic [DATA_WIDTH-1:0] wr_word;
  word_t                 merged_full;
  logic                  unused_merge;

  assign in_range = ({1'b0, addr} < DepthExt);

  // The fault is applied on the read side so merges and reads both see the stuck bit.
  always_comb begin
    cur_word = '0;
    if (in_range) cur_word = mem[addr];
    if (FaultEn && (addr == FaultIdx)) cur_word[0] = 1'b0;
  end

  assign merged_full  = byte_merge(word_t'(cur_word), word_t'(wdata), be_t'(be));
  assign wr_word      = merged_full[DATA_WIDTH-1:0];
  assign unused_merge = ^merged_full;

  always_ff @(posedge clk) begin
    if (req && we && in_range) mem[addr] <= wr_word;
  end

  logic                  v1_q;
  logic [TAG_WIDTH-1:0]  tag1_q;
  logic [DATA_WIDTH-1:0] data1_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q    <= 1'b0;
      tag1_q  <= '0;
      data1_q <= '0;
    end else begin
      v1_q <= req && !we;
      if (req && !we) begin
        tag1_q  <= tag;
        data1_q <= cur_word;
      end
    end
  end

  if (READ_LATENCY == 2) begin : g_lat2
    logic                  v2_q;
    logic [TAG_WIDTH-1:0]  tag2_q;
    logic [DATA_WIDTH-1:0] data2_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v2_q    <= 1'b0;
        tag2_q  <= '0;
        data2_q <= '0;
      end else begin
        v2_q <= v1_q;
        if (v1_q) begin
          tag2_q  <= tag1_q;
          data2_q <= data1_q;
        end
      end
    end

    assign rd_valid = v2_q;
    assign rd_tag   = tag2_q;
    assign rd_data  = data2_q;
  end else begin : g_lat1
    assign rd_valid = v1_q;
    assign rd_tag   = tag1_q;
    assign rd_data  = data1_q;
  end

endmodule

// File: rtl/sp_ram_bist.sv
// Single-port RAM front end: user request port, march self-test FSM (W0,R0,W1,R1,drain)
// and the self-test result registers.
module sp_ram_bist
  import sp_ram_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned RAM_DEPTH    = 8,
  parameter int unsigned ADDR_WIDTH   = $clog2(RAM_DEPTH),
  parameter int unsigned READ_LATENCY = 1,
  parameter int          FAULT_ADDR   = -1
) (
  input  logic                    clk_ip,
  input  logic                    rst_n_ip,
  input  logic                    req_valid_ip,
  output logic                    req_ready_op,
  input  logic                    we_ip,
  input  logic [DATA_WIDTH/8-1:0] be_ip,
  input  logic [ADDR_WIDTH-1:0]   address_ip,
  input  logic [DATA_WIDTH-1:0]   data_ip,
  output logic                    rd_valid_op,
  output logic [DATA_WIDTH-1:0]   rd_data_op,
  input  logic                    bist_start_ip,
  output logic                    bist_busy_op,
  output logic                    bist_done_op,
  output logic                    bist_pass_op,
  output logic [ADDR_WIDTH-1:0]   bist_fail_addr_op
);

  localparam int unsigned           TagWidth = ADDR_WIDTH + 2;
  localparam int unsigned           LastInt  = RAM_DEPTH - 1;
  localparam logic [ADDR_WIDTH-1:0] LastAddr = LastInt[ADDR_WIDTH-1:0];
  localparam logic [DATA_WIDTH-1:0] Ones     = PatOnes[DATA_WIDTH-1:0];
  localparam logic [DATA_WIDTH-1:0] Zero     = PatZero[DATA_WIDTH-1:0];

  bist_state_t           state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  drain_q, drain_d;
  logic                  drain_last;
  logic                  finish;

  logic                    arr_req, arr_we;
  logic [DATA_WIDTH/8-1:0] arr_be;
  logic [ADDR_WIDTH-1:0]   arr_addr;
  logic [DATA_WIDTH-1:0]   arr_wdata;
  // Tag layout: {bist read, expect all-1, address}.
  logic [TagWidth-1:0]     arr_tag, ret_tag;
  logic                    ret_valid;
  logic [DATA_WIDTH-1:0]   ret_data;

  assign drain_last   = (READ_LATENCY == 1) || drain_q;
  assign finish       = (state_q == StDrain) && drain_last;
  assign req_ready_op = (state_q == StIdle) && !bist_start_ip;
  assign bist_busy_op = (state_q != StIdle);

  always_ff @(posedge clk_ip or negedge rst_n_ip) begin
    if (!rst_n_ip) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      drain_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      drain_q <= drain_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    drain_d   = drain_q;
    arr_req   = 1'b0;
    arr_we    = 1'b0;
    arr_be    = '0;
    arr_addr  = address_ip;
    arr_wdata = data_ip;
    arr_tag   = {2'b00, address_ip};
    unique case (state_q)
      StIdle: begin
        if (bist_start_ip) begin
          state_d = StW0;
          cnt_d   = '0;
        end else begin
          arr_req = req_valid_ip;
          arr_we  = we_ip;
          arr_be  = be_ip;
        end
      end
      StW0, StW1: begin
        arr_req   = 1'b1;
        arr_we    = 1'b1;
        arr_be    = '1;
        arr_addr  = cnt_q;
        arr_wdata = (state_q == StW1) ? Ones : Zero;
        if (cnt_q == LastAddr) begin
          cnt_d   = '0;
          state_d = (state_q == StW0) ? StR0 : StR1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StR0, StR1: begin
        arr_req  = 1'b1;
        arr_addr = cnt_q;
        arr_tag  = {1'b1, (state_q == StR1), cnt_q};
        drain_d  = 1'b0;
        if (cnt_q == LastAddr) begin
          cnt_d   = '0;
          state_d = (state_q == StR0) ? StW1 : StDrain;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDrain: begin
        if (drain_last) state_d = StIdle;
        else            drain_d = 1'b1;
      end
      default: state_d = StIdle;
    endcase
  end

  sp_ram_array #(
    .DATA_WIDTH  (DATA_WIDTH),
    .RAM_DEPTH   (RAM_DEPTH),
    .ADDR_WIDTH  (ADDR_WIDTH),
    .READ_LATENCY(READ_LATENCY),
    .FAULT_ADDR  (FAULT_ADDR),
    .TAG_WIDTH   (TagWidth)
  ) u_array (
    .clk     (clk_ip),
    .rst_n   (rst_n_ip),
    .req     (arr_req),
    .we      (arr_we),
    .be      (arr_be),
    .addr    (arr_addr),
    .wdata   (arr_wdata),
    .tag     (arr_tag),
    .rd_valid(ret_valid),
    .rd_tag  (ret_tag),
    .rd_data (ret_data)
  );

  logic                  ret_bist, ret_ones, mismatch;
  logic [ADDR_WIDTH-1:0] ret_addr;
  logic [DATA_WIDTH-1:0] rd_hold_q;
  logic                  done_q, pass_q, fail_seen_q;
  logic [ADDR_WIDTH-1:0] fail_addr_q, first_addr_q;

  assign ret_bist = ret_tag[TagWidth-1];
  assign ret_ones = ret_tag[TagWidth-2];
  assign ret_addr = ret_tag[ADDR_WIDTH-1:0];
  assign mismatch = ret_valid && ret_bist && (ret_data != (ret_ones ? Ones : Zero));

  assign rd_valid_op       = ret_valid && !ret_bist;
  assign rd_data_op        = rd_valid_op ? ret_data : rd_hold_q;
  assign bist_done_op      = done_q;
  assign bist_pass_op      = pass_q;
  assign bist_fail_addr_op = fail_addr_q;

  always_ff @(posedge clk_ip or negedge rst_n_ip) begin
    if (!rst_n_ip) begin
      rd_hold_q    <= '0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      fail_seen_q  <= 1'b0;
      fail_addr_q  <= '0;
      first_addr_q <= '0;
    end else begin
      if (rd_valid_op) rd_hold_q <= ret_data;
      done_q <= finish;
      if ((state_q == StIdle) && bist_start_ip) begin
        fail_seen_q  <= 1'b0;
        first_addr_q <= '0;
      end else if (mismatch && !fail_seen_q) begin
        fail_seen_q  <= 1'b1;
        first_addr_q <= ret_addr;
      end
      // The final compare can land in the same cycle as finish.
      if (finish) begin
        pass_q      <= !(fail_seen_q || mismatch);
        fail_addr_q <= fail_seen_q ? first_addr_q : (mismatch ? ret_addr : '0);
      end
    end
  end

endmodule
